// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: progCntr feedback, instruction-memory handshake and decode-side buffer port.
// The master modport is the fetch unit; the slave modport is its environment (progCntr, memory, decode).
interface fetch_unit_if;
    logic [15:0] NEXT_PC;
    logic        BRANCH;
    logic [15:0] PC;
    logic        IMEM_REQ;
    logic [15:0] IMEM_ADDR;
    logic        IMEM_ACK;
    logic [15:0] IMEM_DATA;
    logic [15:0] INSTR;
    logic [15:0] INSTR_PC;
    logic        INSTR_VALID;
    logic        INSTR_READY;

    modport master (
        input  NEXT_PC, BRANCH, IMEM_ACK, IMEM_DATA, INSTR_READY,
        output PC, IMEM_REQ, IMEM_ADDR, INSTR, INSTR_PC, INSTR_VALID
    );

    modport slave (
        output NEXT_PC, BRANCH, IMEM_ACK, IMEM_DATA, INSTR_READY,
        input  PC, IMEM_REQ, IMEM_ADDR, INSTR, INSTR_PC, INSTR_VALID
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding memory requests
// and buffers returned words in a small circular FIFO drained by decode.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    fetch_unit_if.master  bus
);
    localparam int PW = (DEPTH == 4) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [15:0]   pc_q, pc_d;
    logic [15:0]   addr_q, addr_d;
    logic          req_q;
    logic [CW-1:0] count_q, count_d, count_after;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          push, pop;

    logic [15:0]   data_mem [DEPTH];
    logic [15:0]   pc_mem   [DEPTH];

    always_comb begin
        pop         = (count_q != '0) & bus.INSTR_READY;
        push        = (state_q == FETCH) & bus.IMEM_ACK & ~bus.BRANCH;
        count_after = count_q + CW'(push) - CW'(pop);

        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;

        case (state_q)
            IDLE: begin
                if (bus.BRANCH) begin
                    pc_d    = bus.NEXT_PC;
                    addr_d  = bus.NEXT_PC;
                    state_d = FETCH;
                end else if ((count_q < FULL) || pop) begin
                    addr_d  = pc_q;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (bus.BRANCH) begin
                    pc_d = bus.NEXT_PC;
                    // An unacked request cannot be withdrawn; wait it out in DRAIN.
                    if (bus.IMEM_ACK) addr_d = bus.NEXT_PC;
                    else              state_d = DRAIN;
                end else if (bus.IMEM_ACK) begin
                    pc_d   = bus.NEXT_PC;
                    addr_d = bus.NEXT_PC;
                    if (!(count_after < FULL)) state_d = IDLE;
                end
            end
            DRAIN: begin
                if (bus.BRANCH) pc_d = bus.NEXT_PC;
                if (bus.IMEM_ACK) begin
                    addr_d  = bus.BRANCH ? bus.NEXT_PC : pc_q;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides any push/pop in the same cycle.
        count_d  = bus.BRANCH ? '0 : count_after;
        wr_ptr_d = bus.BRANCH ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d = bus.BRANCH ? '0 : rd_ptr_q + PW'(pop);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            req_q    <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            req_q    <= (state_d != IDLE);
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Buffer storage carries no reset; validity is tracked solely by count_q.
    always_ff @(posedge CLK) begin
        if (push) begin
            data_mem[wr_ptr_q] <= bus.IMEM_DATA;
            pc_mem[wr_ptr_q]   <= addr_q;
        end
    end

    assign bus.PC          = pc_q;
    assign bus.IMEM_REQ    = req_q;
    assign bus.IMEM_ADDR   = addr_q;
    assign bus.INSTR_VALID = (count_q != '0);
    assign bus.INSTR       = (count_q != '0) ? data_mem[rd_ptr_q] : 16'h0000;
    assign bus.INSTR_PC    = (count_q != '0) ? pc_mem[rd_ptr_q]   : 16'h0000;
endmodule
